// File: rtl/chn_wr_pkg.sv
// Shared constants for the short SDRAM write channel: buffer geometry,
// pointer widths and pending-page thresholds.
package chn_wr_pkg;

  localparam int NPAGES_LOG     = 2;
  localparam int PAGE_WORDS_LOG = 5;

  // ra = {page, word}; wa = {page, halfword}
  localparam int RA_W      = NPAGES_LOG + PAGE_WORDS_LOG;
  localparam int WA_W      = RA_W + 1;
  localparam int BUF_DEPTH = 1 << RA_W;

  localparam int PEND_W = 3;
  localparam logic [PEND_W-1:0] PEND_MAX    = 3'd4;
  localparam logic [PEND_W-1:0] PEND_URGENT = 3'd3;

endpackage

// File: rtl/channel_wr_short_if.sv
// Channel-side bundle: arbiter handshake, SDRAM controller side, source halfword
// stream and tile-walk configuration.
interface channel_wr_short_if;

  logic        enrq;
  logic [11:0] fsa;
  logic [7:0]  x_max;
  logic [7:0]  x_shift;
  logic [7:0]  nx_max;
  logic [13:0] y_max;
  logic        start;
  logic        rq_busy;
  logic        rq;
  logic        rq_urgent;
  logic        predrun;
  logic [21:0] sa;
  logic [4:0]  len;
  logic [31:0] sddo;
  logic        ibwe;
  logic [15:0] ibdat;
  logic        ovf;

  // Handshake: rq stays high while a full page is pending; start is a one-cycle
  // grant; predrun strobes one 32-bit word out, with sddo valid one clk later.
  modport master (
    output enrq, fsa, x_max, x_shift, nx_max, y_max, start, rq_busy, predrun,
           ibwe, ibdat,
    input  rq, rq_urgent, sa, len, sddo, ovf
  );

  modport slave (
    input  enrq, fsa, x_max, x_shift, nx_max, y_max, start, rq_busy, predrun,
           ibwe, ibdat,
    output rq, rq_urgent, sa, len, sddo, ovf
  );

endinterface

// File: rtl/chn_wr_buf.sv
// Simple dual-port page buffer: one write port, one registered read port with a
// synchronous clear on the output register; both on the falling edge.
module chn_wr_buf #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(negedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(negedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/channel_wr_short.sv
// Short SDRAM write channel: packs a halfword stream into a 4-page buffer and
// requests the arbiter per full page. Optional sticky overflow: CHN_WR_OVF_EN.
module channel_wr_short
  import chn_wr_pkg::*;
(
  input  logic              clk,
  input  logic              init,
  channel_wr_short_if.slave bus
);

  logic [WA_W-1:0]   wa;
  logic [RA_W-1:0]   ra;
  logic [15:0]       lo_hw;
  logic [PEND_W-1:0] pend;
  logic              predrun_d;
  logic [6:0]        nx;
  logic [7:0]        nx_cnt;
  logic [13:0]       yb;      // {y, bank}
  logic              rq_r;
  logic              rq_urgent_r;
  logic [21:0]       sa_r;
  logic [4:0]        len_r;

  logic wr_drop;
  logic mem_we;
  logic page_done;
  logic done;

  always_comb begin
    wr_drop   = bus.ibwe & (pend == PEND_MAX);
    mem_we    = bus.ibwe & ~wr_drop & wa[0] & ~init;
    page_done = mem_we & (wa[5:0] == {bus.x_max[4:0], 1'b1});
    done      = predrun_d & ~bus.predrun;
  end

  always_ff @(negedge clk) begin
    len_r <= bus.x_max[4:0];
    if (init) begin
      wa          <= '0;
      ra          <= '0;
      lo_hw       <= '0;
      pend        <= '0;
      predrun_d   <= 1'b0;
      nx          <= '0;
      nx_cnt      <= '0;
      yb          <= '0;
      rq_r        <= 1'b0;
      rq_urgent_r <= 1'b0;
      sa_r        <= {bus.fsa, 10'b0};
    end else begin
      predrun_d <= bus.predrun;

      if (bus.ibwe && !wr_drop) begin
        if (!wa[0]) begin
          lo_hw <= bus.ibdat;
          wa    <= wa + 8'd1;
        end else if (page_done) begin
          wa <= {wa[7:6] + 2'd1, 6'd0};
        end else begin
          wa <= wa + 8'd1;
        end
      end

      if (done)             ra <= {ra[6:5] + 2'd1, 5'd0};
      else if (bus.predrun) ra <= {ra[6:5], ra[4:0] + 5'd1};

      // A completion and a done in the same cycle cancel out
      if (page_done && !done)                     pend <= pend + 3'd1;
      else if (done && !page_done && pend != '0)  pend <= pend - 3'd1;

      rq_r        <= bus.enrq & (pend != '0) & ~(bus.start & (pend == 3'd1));
      rq_urgent_r <= bus.enrq & (pend >= PEND_URGENT);

      // Grant latches the address built from the counters as they were before it
      if (bus.start) begin
        sa_r <= {sa_r[21], sa_r[20], yb[11:2], 1'b0, nx, yb[1:0]};
        if (nx_cnt == bus.nx_max) begin
          nx     <= '0;
          nx_cnt <= '0;
          yb     <= (yb == bus.y_max) ? 14'd0 : yb + 14'd1;
        end else begin
          nx     <= nx + bus.x_shift[6:0];
          nx_cnt <= nx_cnt + 8'd1;
        end
      end
    end
  end

  chn_wr_buf #(.AW(RA_W), .DW(32)) u_buf (
    .clk   (clk),
    .rst   (init),
    .we    (mem_we),
    .waddr ({wa[7:6], wa[5:1]}),
    .wdata ({bus.ibdat, lo_hw}),
    .re    (bus.predrun),
    .raddr (ra),
    .rdata (bus.sddo)
  );

`ifdef CHN_WR_OVF_EN
  logic ovf_r;
  always_ff @(negedge clk) begin
    if (init)         ovf_r <= 1'b0;
    else if (wr_drop) ovf_r <= 1'b1;
  end
  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.rq        = rq_r;
  assign bus.rq_urgent = rq_urgent_r;
  assign bus.sa        = sa_r;
  assign bus.len       = len_r;

  logic unused_bits;
  assign unused_bits = ^{bus.x_max[7:5], bus.x_shift[7], yb[13:12], bus.rq_busy};

endmodule

// File: tb/tb_channel_wr_short.sv
// Directed bench for channel_wr_short: main thread drives and checks control
// outputs; a monitor pops expected sddo words from a queue.
module tb_channel_wr_short;

  logic clk = 1'b0;
  logic init;

  channel_wr_short_if bus();

  channel_wr_short dut (
    .clk  (clk),
    .init (init),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic rd_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // sddo is registered on the falling edge after a predrun cycle
  always @(negedge clk) rd_vld <= bus.predrun & ~init;

  always @(posedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sddo_unexpected: got %h expected none", bus.sddo);
      end else begin
        check("sddo", bus.sddo, exp_q.pop_front());
      end
    end
  end

  task automatic push_hw(input logic [15:0] d);
    bus.ibwe  = 1'b1;
    bus.ibdat = d;
    @(posedge clk);
    bus.ibwe  = 1'b0;
  endtask

  task automatic grant();
    bus.start = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
  endtask

  // Four predrun cycles of a page whose halfwords are base, base+1, ...
  task automatic burst(input logic [15:0] base);
    for (int w = 0; w < 4; w++) begin
      bus.predrun = 1'b1;
      exp_q.push_back({base + 16'(2*w + 1), base + 16'(2*w)});
      @(posedge clk);
    end
    bus.predrun = 1'b0;
  endtask

  logic exp_ovf;
  logic [13:0] yb_e;
  logic [6:0]  nx_e;

  initial begin
`ifdef CHN_WR_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    init        = 1'b1;
    bus.enrq    = 1'b0;
    bus.fsa     = 12'h3A5;
    bus.x_max   = 8'd3;
    bus.x_shift = 8'd0;
    bus.nx_max  = 8'd0;
    bus.y_max   = 14'd0;
    bus.start   = 1'b0;
    bus.rq_busy = 1'b0;
    bus.predrun = 1'b0;
    bus.ibwe    = 1'b0;
    bus.ibdat   = 16'h0;
    repeat (2) @(posedge clk);

    // Reset state
    check("rst_sa", bus.sa, 32'h0E9400);
    check("rst_rq", bus.rq, 0);
    check("rst_urgent", bus.rq_urgent, 0);
    check("rst_pend", dut.pend, 0);
    check("rst_sddo", bus.sddo, 0);
    check("rst_len", bus.len, 3);
    check("rst_ovf", bus.ovf, 0);
    init     = 1'b0;
    bus.enrq = 1'b1;

    // Single page of 8 halfwords
    for (int i = 1; i <= 8; i++) push_hw(16'(i));
    check("t2_rq_pre", bus.rq, 0);
    check("t2_pend", dut.pend, 1);
    @(posedge clk);
    check("t2_rq", bus.rq, 1);
    grant();
    check("t2_rq_grant", bus.rq, 0);
    burst(16'h0001);
    repeat (2) @(posedge clk);
    check("t2_rq_done", bus.rq, 0);
    check("t2_pend_done", dut.pend, 0);

    // Fill all four pages without a grant, then overflow
    for (int i = 0; i < 24; i++) push_hw(16'h1000 + 16'(i));
    check("t3_urgent_pre", bus.rq_urgent, 0);
    check("t3_pend3", dut.pend, 3);
    @(posedge clk);
    check("t3_urgent", bus.rq_urgent, 1);
    for (int i = 24; i < 32; i++) push_hw(16'h1000 + 16'(i));
    check("t3_pend4", dut.pend, 4);
    check("t3_ovf_pre", bus.ovf, 0);
    push_hw(16'hDEAD);
    check("t3_wa_hold", dut.wa, 8'h40);
    check("t3_pend_hold", dut.pend, 4);
    check("t3_ovf", bus.ovf, exp_ovf);
    grant();
    burst(16'h1000);
    @(posedge clk);
    grant();
    burst(16'h1008);
    @(posedge clk);
    check("t3_pend2", dut.pend, 2);

    // Page completion coinciding with done
    for (int i = 0; i < 7; i++) push_hw(16'h2000 + 16'(i));
    check("t4_pend_pre", dut.pend, 2);
    grant();
    burst(16'h1010);
    push_hw(16'h2007);
    check("t4_pend", dut.pend, 2);
    check("t4_wa", dut.wa, 8'h80);
    @(posedge clk);
    check("t4_rq", bus.rq, 1);

    // Init during the second predrun cycle
    grant();
    bus.predrun = 1'b1;
    exp_q.push_back(32'h10191018);
    @(posedge clk);
    init = 1'b1;
    @(posedge clk);
    init        = 1'b0;
    bus.predrun = 1'b0;
    check("t6_ra", dut.ra, 0);
    check("t6_pend", dut.pend, 0);
    check("t6_rq", bus.rq, 0);
    check("t6_sddo", bus.sddo, 0);
    check("t6_sa", bus.sa, 32'h0E9400);
    check("t6_ovf", bus.ovf, 0);
    for (int i = 0; i < 8; i++) push_hw(16'h3000 + 16'(i));
    @(posedge clk);
    check("t6_rq_fresh", bus.rq, 1);
    grant();
    burst(16'h3000);
    repeat (2) @(posedge clk);
    check("t6_pend_end", dut.pend, 0);

    // Address walk through nx, {y,bank} and the y_max wrap
    bus.fsa = 12'hE00;
    init    = 1'b1;
    @(posedge clk);
    init        = 1'b0;
    bus.enrq    = 1'b0;
    bus.x_shift = 8'd8;
    bus.nx_max  = 8'd2;
    bus.y_max   = 14'd5;
    for (int i = 0; i < 21; i++) begin
      grant();
      yb_e = 14'((i / 3) % 6);
      nx_e = 7'((i % 3) * 8);
      check($sformatf("t5_sa_%0d", i), bus.sa, {10'd0, 2'b11, yb_e[11:2], 1'b0, nx_e, yb_e[1:0]});
    end

    repeat (3) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
